// File: rtl/dec_ex_stage_if.sv
// Decode-to-execute bundle: decode-side fields, flush request, and the
// registered EX-side copies plus stall outputs produced by dec_ex_stage.
interface dec_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic [4:0]        dec_rs;
    logic [4:0]        dec_rt;
    logic [4:0]        dec_rd;
    logic [DATA_W-1:0] dec_rd1;
    logic [DATA_W-1:0] dec_rd2;
    logic [DATA_W-1:0] dec_imm;
    logic              dec_regwrite;
    logic              dec_memtoreg;
    logic              dec_memwrite;
    logic              dec_alusrc;
    logic              dec_regdst;
    logic [2:0]        dec_alucontrol;
    logic              dec_valid;
    logic              dec_uses_rt;
    logic              ex_flush;

    logic [4:0]        dec_ex_rs;
    logic [4:0]        dec_ex_rt;
    logic [4:0]        dec_ex_rd;
    logic [DATA_W-1:0] dec_ex_rd1;
    logic [DATA_W-1:0] dec_ex_rd2;
    logic [DATA_W-1:0] dec_ex_imm;
    logic              dec_ex_regwrite;
    logic              dec_ex_memtoreg;
    logic              dec_ex_memwrite;
    logic              dec_ex_alusrc;
    logic              dec_ex_regdst;
    logic [2:0]        dec_ex_alucontrol;
    logic              dec_ex_valid;
    logic              stall_fd;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output dec_rs, dec_rt, dec_rd, dec_rd1, dec_rd2, dec_imm,
               dec_regwrite, dec_memtoreg, dec_memwrite, dec_alusrc, dec_regdst,
               dec_alucontrol, dec_valid, dec_uses_rt, ex_flush,
        input  dec_ex_rs, dec_ex_rt, dec_ex_rd, dec_ex_rd1, dec_ex_rd2, dec_ex_imm,
               dec_ex_regwrite, dec_ex_memtoreg, dec_ex_memwrite, dec_ex_alusrc,
               dec_ex_regdst, dec_ex_alucontrol, dec_ex_valid, stall_fd, stall_count
    );

    modport slave (
        input  dec_rs, dec_rt, dec_rd, dec_rd1, dec_rd2, dec_imm,
               dec_regwrite, dec_memtoreg, dec_memwrite, dec_alusrc, dec_regdst,
               dec_alucontrol, dec_valid, dec_uses_rt, ex_flush,
        output dec_ex_rs, dec_ex_rt, dec_ex_rd, dec_ex_rd1, dec_ex_rd2, dec_ex_imm,
               dec_ex_regwrite, dec_ex_memtoreg, dec_ex_memwrite, dec_ex_alusrc,
               dec_ex_regdst, dec_ex_alucontrol, dec_ex_valid, stall_fd, stall_count
    );
endinterface

// File: rtl/dec_ex_stage.sv
// Decode/execute pipeline register with load-use hazard detection, flush
// bubbling and a saturating stall-cycle counter.
module dec_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic           clk,
    input  logic           reset,
    dec_ex_stage_if.slave  bus
);
    logic hazard;
    logic bubble;

    // Only a valid load in EX whose destination is a real register can stall.
    always_comb begin
        hazard = bus.dec_ex_valid & bus.dec_ex_memtoreg & (bus.dec_ex_rt != 5'd0) &
                 bus.dec_valid &
                 ((bus.dec_ex_rt == bus.dec_rs) |
                  (bus.dec_uses_rt & (bus.dec_ex_rt == bus.dec_rt)));
        bubble = hazard | bus.ex_flush | ~bus.dec_valid;
    end

    assign bus.stall_fd = hazard & ~bus.ex_flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.dec_ex_rs         <= '0;
            bus.dec_ex_rt         <= '0;
            bus.dec_ex_rd         <= '0;
            bus.dec_ex_rd1        <= '0;
            bus.dec_ex_rd2        <= '0;
            bus.dec_ex_imm        <= '0;
            bus.dec_ex_regwrite   <= 1'b0;
            bus.dec_ex_memtoreg   <= 1'b0;
            bus.dec_ex_memwrite   <= 1'b0;
            bus.dec_ex_alusrc     <= 1'b0;
            bus.dec_ex_regdst     <= 1'b0;
            bus.dec_ex_alucontrol <= '0;
            bus.dec_ex_valid      <= 1'b0;
        end else if (bubble) begin
            bus.dec_ex_rs         <= '0;
            bus.dec_ex_rt         <= '0;
            bus.dec_ex_rd         <= '0;
            bus.dec_ex_rd1        <= '0;
            bus.dec_ex_rd2        <= '0;
            bus.dec_ex_imm        <= '0;
            bus.dec_ex_regwrite   <= 1'b0;
            bus.dec_ex_memtoreg   <= 1'b0;
            bus.dec_ex_memwrite   <= 1'b0;
            bus.dec_ex_alusrc     <= 1'b0;
            bus.dec_ex_regdst     <= 1'b0;
            bus.dec_ex_alucontrol <= '0;
            bus.dec_ex_valid      <= 1'b0;
        end else begin
            bus.dec_ex_rs         <= bus.dec_rs;
            bus.dec_ex_rt         <= bus.dec_rt;
            bus.dec_ex_rd         <= bus.dec_rd;
            bus.dec_ex_rd1        <= bus.dec_rd1;
            bus.dec_ex_rd2        <= bus.dec_rd2;
            bus.dec_ex_imm        <= bus.dec_imm;
            bus.dec_ex_regwrite   <= bus.dec_regwrite;
            bus.dec_ex_memtoreg   <= bus.dec_memtoreg;
            bus.dec_ex_memwrite   <= bus.dec_memwrite;
            bus.dec_ex_alusrc     <= bus.dec_alusrc;
            bus.dec_ex_regdst     <= bus.dec_regdst;
            bus.dec_ex_alucontrol <= bus.dec_alucontrol;
            bus.dec_ex_valid      <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.stall_count <= '0;
        end else if (bus.stall_fd && (bus.stall_count != {CNT_W{1'b1}})) begin
            bus.stall_count <= bus.stall_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_dec_ex_stage.sv
// Directed bench for dec_ex_stage: a default-width instance and a 2-bit
// counter instance share the same decode stimulus.
`timescale 1ns/1ps
module tb_dec_ex_stage;
    localparam int DATA_W = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic run   = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    logic [4:0]        d_rs, d_rt, d_rd;
    logic [DATA_W-1:0] d_rd1, d_rd2, d_imm;
    logic              d_regwrite, d_memtoreg, d_memwrite, d_alusrc, d_regdst;
    logic [2:0]        d_aluc;
    logic              d_valid, d_uses_rt, d_flush;

    int sat_exp [5] = '{1, 2, 3, 3, 3};

    dec_ex_stage_if #(.DATA_W(DATA_W), .CNT_W(16)) bus0 ();
    dec_ex_stage_if #(.DATA_W(DATA_W), .CNT_W(2))  bus1 ();

    dec_ex_stage #(.DATA_W(DATA_W), .CNT_W(16)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
    dec_ex_stage #(.DATA_W(DATA_W), .CNT_W(2))  u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

    assign bus0.dec_rs = d_rs;             assign bus1.dec_rs = d_rs;
    assign bus0.dec_rt = d_rt;             assign bus1.dec_rt = d_rt;
    assign bus0.dec_rd = d_rd;             assign bus1.dec_rd = d_rd;
    assign bus0.dec_rd1 = d_rd1;           assign bus1.dec_rd1 = d_rd1;
    assign bus0.dec_rd2 = d_rd2;           assign bus1.dec_rd2 = d_rd2;
    assign bus0.dec_imm = d_imm;           assign bus1.dec_imm = d_imm;
    assign bus0.dec_regwrite = d_regwrite; assign bus1.dec_regwrite = d_regwrite;
    assign bus0.dec_memtoreg = d_memtoreg; assign bus1.dec_memtoreg = d_memtoreg;
    assign bus0.dec_memwrite = d_memwrite; assign bus1.dec_memwrite = d_memwrite;
    assign bus0.dec_alusrc = d_alusrc;     assign bus1.dec_alusrc = d_alusrc;
    assign bus0.dec_regdst = d_regdst;     assign bus1.dec_regdst = d_regdst;
    assign bus0.dec_alucontrol = d_aluc;   assign bus1.dec_alucontrol = d_aluc;
    assign bus0.dec_valid = d_valid;       assign bus1.dec_valid = d_valid;
    assign bus0.dec_uses_rt = d_uses_rt;   assign bus1.dec_uses_rt = d_uses_rt;
    assign bus0.ex_flush = d_flush;        assign bus1.ex_flush = d_flush;

    always #5 if (run) clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic set_dec(input logic valid, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [DATA_W-1:0] rd1,
                           input logic [DATA_W-1:0] rd2, input logic [DATA_W-1:0] imm,
                           input logic regwrite, input logic memtoreg, input logic alusrc,
                           input logic regdst, input logic [2:0] aluc, input logic uses_rt);
        d_valid = valid; d_rs = rs; d_rt = rt; d_rd = rd;
        d_rd1 = rd1; d_rd2 = rd2; d_imm = imm;
        d_regwrite = regwrite; d_memtoreg = memtoreg; d_memwrite = 1'b0;
        d_alusrc = alusrc; d_regdst = regdst; d_aluc = aluc; d_uses_rt = uses_rt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"},    64'(bus0.dec_ex_valid),    64'd0);
        chk({tag, "_rs"},       64'(bus0.dec_ex_rs),       64'd0);
        chk({tag, "_rt"},       64'(bus0.dec_ex_rt),       64'd0);
        chk({tag, "_regwrite"}, 64'(bus0.dec_ex_regwrite), 64'd0);
        chk({tag, "_memtoreg"}, 64'(bus0.dec_ex_memtoreg), 64'd0);
        chk({tag, "_rd1"},      64'(bus0.dec_ex_rd1),      64'd0);
    endtask

    initial begin
        d_flush = 1'b0;
        set_dec(1'b0, 5'd0, 5'd0, 5'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

        // reset with the clock idle
        #1 reset = 1'b1;
        #1;
        chk_bubble("rst");
        chk("rst_imm",    64'(bus0.dec_ex_imm),  64'd0);
        chk("rst_stall",  64'(bus0.stall_fd),    64'd0);
        chk("rst_cnt0",   64'(bus0.stall_count), 64'd0);
        chk("rst_cnt1",   64'(bus1.stall_count), 64'd0);
        #1 reset = 1'b0;

        // pass-through
        set_dec(1'b1, 5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 32'hFFFF_FFFC,
                1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1);
        run = 1'b1;
        #1;
        chk("pre_edge_valid", 64'(bus0.dec_ex_valid), 64'd0);
        chk("pass_stall",     64'(bus0.stall_fd),     64'd0);
        step();
        chk("pass_valid", 64'(bus0.dec_ex_valid),      64'd1);
        chk("pass_rs",    64'(bus0.dec_ex_rs),         64'd3);
        chk("pass_rt",    64'(bus0.dec_ex_rt),         64'd4);
        chk("pass_rd",    64'(bus0.dec_ex_rd),         64'd5);
        chk("pass_rd1",   64'(bus0.dec_ex_rd1),        64'h11);
        chk("pass_rd2",   64'(bus0.dec_ex_rd2),        64'h22);
        chk("pass_imm",   64'(bus0.dec_ex_imm),        64'hFFFF_FFFC);
        chk("pass_rw",    64'(bus0.dec_ex_regwrite),   64'd1);
        chk("pass_aluc",  64'(bus0.dec_ex_alucontrol), 64'd2);
        chk("pass_m2r",   64'(bus0.dec_ex_memtoreg),   64'd0);

        // load-use on rs: lw r8 then add r10 = r8 + r9
        set_dec(1'b1, 5'd1, 5'd8, 5'd0, 32'h100, 32'h0, 32'h4,
                1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0);
        step();
        chk("lw_rt",  64'(bus0.dec_ex_rt),       64'd8);
        chk("lw_m2r", 64'(bus0.dec_ex_memtoreg), 64'd1);
        set_dec(1'b1, 5'd8, 5'd9, 5'd10, 32'h7, 32'h9, 32'h0,
                1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1);
        #1;
        chk("lu_stall", 64'(bus0.stall_fd), 64'd1);
        step();
        chk_bubble("lu_bubble");
        chk("lu_cnt",      64'(bus0.stall_count), 64'd1);
        chk("lu_unstall",  64'(bus0.stall_fd),    64'd0);
        step();
        chk("lu_adv_valid", 64'(bus0.dec_ex_valid), 64'd1);
        chk("lu_adv_rs",    64'(bus0.dec_ex_rs),    64'd8);
        chk("lu_adv_rd",    64'(bus0.dec_ex_rd),    64'd10);
        chk("lu_adv_rd2",   64'(bus0.dec_ex_rd2),   64'h9);
        chk("lu_cnt_hold",  64'(bus0.stall_count),  64'd1);

        // lw to r0 never stalls
        set_dec(1'b1, 5'd2, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,
                1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0);
        step();
        set_dec(1'b1, 5'd0, 5'd0, 5'd6, 32'h0, 32'h0, 32'h0,
                1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1);
        #1;
        chk("r0_stall", 64'(bus0.stall_fd), 64'd0);
        step();
        chk("r0_valid", 64'(bus0.dec_ex_valid), 64'd1);
        chk("r0_rd",    64'(bus0.dec_ex_rd),    64'd6);

        // rt match ignored when rt is not a source
        set_dec(1'b1, 5'd1, 5'd8, 5'd0, 32'h0, 32'h0, 32'h0,
                1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0);
        step();
        set_dec(1'b1, 5'd3, 5'd8, 5'd0, 32'h0, 32'h0, 32'h8,
                1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0);
        #1;
        chk("nort_stall", 64'(bus0.stall_fd), 64'd0);
        step();
        chk("nort_valid", 64'(bus0.dec_ex_valid), 64'd1);
        chk("nort_imm",   64'(bus0.dec_ex_imm),   64'h8);
        chk("nort_cnt",   64'(bus0.stall_count),  64'd1);

        // flush beats a simultaneous rt hazard
        set_dec(1'b1, 5'd1, 5'd8, 5'd0, 32'h0, 32'h0, 32'h0,
                1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0);
        step();
        set_dec(1'b1, 5'd1, 5'd8, 5'd11, 32'h5, 32'h6, 32'h0,
                1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1);
        d_flush = 1'b1;
        #1;
        chk("fl_stall", 64'(bus0.stall_fd), 64'd0);
        step();
        d_flush = 1'b0;
        chk_bubble("fl_bubble");
        chk("fl_cnt", 64'(bus0.stall_count), 64'd1);

        // rt hazard with rt used does stall
        set_dec(1'b1, 5'd1, 5'd8, 5'd0, 32'h0, 32'h0, 32'h0,
                1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0);
        step();
        set_dec(1'b1, 5'd1, 5'd8, 5'd11, 32'h5, 32'h6, 32'h0,
                1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1);
        #1;
        chk("rt_stall", 64'(bus0.stall_fd), 64'd1);
        step();
        chk("rt_bubble", 64'(bus0.dec_ex_valid), 64'd0);
        chk("rt_cnt",    64'(bus0.stall_count),  64'd2);

        // reset in the middle of a stall
        set_dec(1'b1, 5'd1, 5'd8, 5'd0, 32'h0, 32'h0, 32'h0,
                1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0);
        step();
        set_dec(1'b1, 5'd8, 5'd9, 5'd10, 32'h0, 32'h0, 32'h0,
                1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1);
        #1;
        chk("mr_stall_pre", 64'(bus0.stall_fd), 64'd1);
        reset = 1'b1;
        #1;
        chk("mr_stall", 64'(bus0.stall_fd),        64'd0);
        chk("mr_m2r",   64'(bus0.dec_ex_memtoreg), 64'd0);
        chk("mr_cnt0",  64'(bus0.stall_count),     64'd0);
        chk("mr_cnt1",  64'(bus1.stall_count),     64'd0);
        reset = 1'b0;

        // saturation of the 2-bit counter across five stalls
        for (int i = 0; i < 5; i++) begin
            set_dec(1'b1, 5'd1, 5'd8, 5'd0, 32'h0, 32'h0, 32'h0,
                    1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0);
            step();
            set_dec(1'b1, 5'd8, 5'd9, 5'd10, 32'h0, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1);
            #1;
            chk($sformatf("sat_stall%0d", i), 64'(bus1.stall_fd), 64'd1);
            step();
            chk($sformatf("sat_cnt1_%0d", i), 64'(bus1.stall_count), 64'(sat_exp[i]));
            chk($sformatf("sat_cnt0_%0d", i), 64'(bus0.stall_count), 64'(i + 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dec_ex_stage.md
DEC_EX_STAGE -- requirements
Module: dec_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of register-file operands and immediate.
REQ-002 SHALL have parameter CNT_W, default 16, width of stall performance counter.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports dec_rs, dec_rt, dec_rd  in  5 each  register specifiers of the instruction in decode.
REQ-006 SHALL have ports dec_rd1, dec_rd2, dec_imm  in  DATA_W each  operand A, operand B, sign-extended immediate from decode.
REQ-007 SHALL have ports dec_regwrite, dec_memtoreg, dec_memwrite, dec_alusrc, dec_regdst  in  1 each  decode control bits.
REQ-008 SHALL have port dec_alucontrol  in  3  ALU operation select.
REQ-009 SHALL have port dec_valid  in  1  decode holds a real instruction.
REQ-010 SHALL have port dec_uses_rt  in  1  decode instruction reads rt as a source.
REQ-011 SHALL have port ex_flush  in  1  branch/jump redirect; kill instruction in decode.
REQ-012 SHALL have registered outputs dec_ex_rs, dec_ex_rt, dec_ex_rd (5), dec_ex_rd1, dec_ex_rd2, dec_ex_imm (DATA_W), dec_ex_regwrite, dec_ex_memtoreg, dec_ex_memwrite, dec_ex_alusrc, dec_ex_regdst (1), dec_ex_alucontrol (3), dec_ex_valid (1)  out  captured copies of decode inputs.
REQ-013 SHALL have port stall_fd  out  1  hold PC and fetch/decode register this cycle.
REQ-014 SHALL have port stall_count  out  CNT_W  number of load-use stall cycles since reset.

Function
REQ-015 SHALL compute hazard = dec_ex_valid & dec_ex_memtoreg & (dec_ex_rt != 0) & dec_valid & ((dec_ex_rt == dec_rs) | (dec_uses_rt & dec_ex_rt == dec_rt)), combinationally from current registers and inputs.
REQ-016 SHALL drive stall_fd = hazard & ~ex_flush, combinationally, same cycle.
REQ-017 SHALL load a bubble on the clock edge when hazard, ex_flush, or ~dec_valid is true.
REQ-018 Bubble SHALL set every registered output, including rs/rt/rd, data fields and dec_ex_valid, to 0, so downstream forwarding sees register 0 and no write.
REQ-019 Otherwise SHALL capture all dec_* inputs into the matching dec_ex_* registers, with dec_ex_valid = 1; latency one cycle.
REQ-020 A load-use hazard SHALL stall exactly one cycle: the bubble clears dec_ex_memtoreg, so hazard deasserts next cycle and the held instruction then advances.
REQ-021 On ex_flush with simultaneous hazard, flush SHALL win: bubble loaded, stall_fd = 0, stall_count unchanged.
REQ-022 stall_count SHALL increment by 1 on each edge where stall_fd = 1, saturating at 2^CNT_W-1 (no wrap).
REQ-023 A hazard on rt SHALL be ignored when dec_uses_rt = 0; register-0 matches SHALL never stall.
REQ-024 No combinational path SHALL exist from dec_* data inputs (rd1, rd2, imm) to any output.

Reset
REQ-025 While reset = 1, all registered outputs and stall_count SHALL be 0 immediately, regardless of clk.
REQ-026 Reset asserted mid-stall SHALL clear dec_ex_memtoreg, forcing stall_fd to 0 in the same cycle.
REQ-027 After reset deassertion, first capture SHALL occur on the first rising edge with reset = 0.

Verification
REQ-028 Reset: assert reset with clk idle -> all outputs 0, stall_count = 0, stall_fd = 0.
REQ-029 Pass-through: dec_valid = 1, rs = 3, rt = 4, rd = 5, rd1 = 0x11, imm = 0xFFFFFFFC, regwrite = 1 -> next cycle identical values on dec_ex_*, dec_ex_valid = 1.
REQ-030 Load-use: lw with rt = 8 in EX, decode add with rs = 8 -> stall_fd = 1 for one cycle, bubble (all zero) in EX next, add enters EX the cycle after, stall_count = 1.
REQ-031 Non-hazards: lw with rt = 0 in EX and decode rs = 0; lw with rt = 8 and decode rt = 8 with dec_uses_rt = 0 -> stall_fd = 0, no bubble.
REQ-032 Flush priority: hazard and ex_flush both 1 -> stall_fd = 0, bubble loaded, stall_count unchanged.
REQ-033 Saturation: CNT_W = 2, force 5 stall cycles -> stall_count reads 1, 2, 3, 3, 3.
